etapa_fetch: RTL

//  Instruction-fetch stage: owns the program counter, drives the word address of the

---
 rtl/etapa_fetch.sv | 87 ++++++++
 1 files changed

// File: rtl/etapa_fetch.sv
// Instruction-fetch stage: program counter, synchronous instruction-memory addressing,
// IF/ID pipeline register, stall/redirect handling and halt detection.
module etapa_fetch #(
  parameter int                 ADDR_W    = 10,
  parameter int                 DATA_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [DATA_W-1:0]  HALT_WORD = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_instr,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc1,
  output logic              if_id_valid,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc1_q, pc1_d;
  logic              valid_q, valid_d;
  logic [31:0]       count_q, count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc1_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Memory and pc latch pc_d on the same edge, so mem_instr always belongs to pc.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    count_d = count_q;
    if (reset) begin
      pc_d = RESET_PC;
    end else if (redirect) begin
      pc_d    = redirect_addr;
      instr_d = '0;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (state_q == HALTED) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = mem_instr;
      pc1_d   = pc_q + 1'b1;
      valid_d = 1'b1;
      count_d = count_q + 32'd1;
      // The HLT word itself is delivered; only the pc freezes.
      if (mem_instr == HALT_WORD) state_d = HALTED;
      else                        pc_d    = pc_q + 1'b1;
    end
  end

  assign mem_addr    = pc_d;
  assign pc          = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc1   = pc1_q;
  assign if_id_valid = valid_q;
  assign halted      = (state_q == HALTED);
  assign fetch_count = count_q;

endmodule
